// File: rtl/cbuf_fmt_pkg.sv
// Shared CBUF word format: tags, header marker, header field positions and parser states.
// The writer-side acquisition mux uses the same bit positions.
package cbuf_fmt_pkg;

  localparam int WORD_W    = 132;
  localparam int PAYLOAD_W = 128;

  localparam logic [3:0] TAG_FILL = 4'd1;
  localparam logic [3:0] TAG_WFM  = 4'd2;
  localparam logic [3:0] TAG_DAT  = 4'd3;
  localparam logic [3:0] TAG_CHK  = 4'd4;

  localparam logic [1:0] HDR_MARK = 2'b01;
  localparam int MARK_MSB = 127;
  localparam int MARK_LSB = 126;

  // fill header (tag 1)
  localparam int FH_FILL_NUM_MSB  = 23;
  localparam int FH_FILL_NUM_LSB  = 0;
  localparam int FH_FILL_TYPE_MSB = 25;
  localparam int FH_FILL_TYPE_LSB = 24;
  localparam int FH_NBURST_MSB    = 40;
  localparam int FH_NBURST_LSB    = 27;
  localparam int FH_PRE_LO_MSB    = 52;
  localparam int FH_PRE_LO_LSB    = 41;
  localparam int FH_ADR_MSB       = 75;
  localparam int FH_ADR_LSB       = 53;
  localparam int FH_ONE_MSB       = 98;
  localparam int FH_ONE_LSB       = 76;
  localparam int FH_PRE_HI_MSB    = 102;
  localparam int FH_PRE_HI_LSB    = 99;
  localparam int FH_SANE_BIT      = 103;
  localparam int FH_CHAN_MSB      = 121;
  localparam int FH_CHAN_LSB      = 110;

  // waveform header (tag 2)
  localparam int WH_NBURST_MSB = 13;
  localparam int WH_NBURST_LSB = 0;
  localparam int WH_ADR_MSB    = 51;
  localparam int WH_ADR_LSB    = 26;
  localparam int WH_CHAN_MSB   = 109;
  localparam int WH_CHAN_LSB   = 98;
  localparam int WH_ALARM_MSB  = 113;
  localparam int WH_ALARM_LSB  = 110;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WFM_HDR,
    ST_DATA,
    ST_CHECK
  } state_e;

endpackage

// File: rtl/cbuf_fill_parser_if.sv
// Tagged-word input stream and burst output stream of the CBUF fill parser.
interface cbuf_fill_parser_if;
  import cbuf_fmt_pkg::*;

  logic [WORD_W-1:0]    in_dat;
  logic                 in_valid;
  logic                 in_ready;
  logic [PAYLOAD_W-1:0] dat_out;
  logic                 dat_valid;
  logic                 dat_ready;
  logic                 dat_last;

  modport master (
    output in_dat, in_valid, dat_ready,
    input  in_ready, dat_out, dat_valid, dat_last
  );

  modport slave (
    input  in_dat, in_valid, dat_ready,
    output in_ready, dat_out, dat_valid, dat_last
  );

endinterface

// File: rtl/cbuf_hdr_decode.sv
// Combinational field extraction and sanity checks for fill and waveform headers.
module cbuf_hdr_decode
  import cbuf_fmt_pkg::*;
(
  input  logic [121:0] hdr,
  input  logic [13:0]  cur_num_bursts,
  input  logic [22:0]  cur_start_adr,
  input  logic [11:0]  cur_channel_tag,
  output logic [23:0]  fill_num,
  output logic [1:0]   fill_type,
  output logic [13:0]  num_bursts,
  output logic [15:0]  pre_trig,
  output logic [22:0]  start_adr,
  output logic [11:0]  channel_tag,
  output logic [3:0]   alarms,
  output logic         fill_sane,
  output logic         wfm_ok
);

  assign fill_num    = hdr[FH_FILL_NUM_MSB:FH_FILL_NUM_LSB];
  assign fill_type   = hdr[FH_FILL_TYPE_MSB:FH_FILL_TYPE_LSB];
  assign num_bursts  = hdr[FH_NBURST_MSB:FH_NBURST_LSB];
  assign pre_trig    = {hdr[FH_PRE_HI_MSB:FH_PRE_HI_LSB], hdr[FH_PRE_LO_MSB:FH_PRE_LO_LSB]};
  assign start_adr   = hdr[FH_ADR_MSB:FH_ADR_LSB];
  assign channel_tag = hdr[FH_CHAN_MSB:FH_CHAN_LSB];
  assign alarms      = hdr[WH_ALARM_MSB:WH_ALARM_LSB];

  assign fill_sane = hdr[FH_SANE_BIT] && (hdr[FH_ONE_MSB:FH_ONE_LSB] == 23'd1);

  // waveform header is cross-checked against the fields latched from the fill header
  assign wfm_ok = (hdr[WH_NBURST_MSB:WH_NBURST_LSB] == cur_num_bursts)
               && (hdr[WH_ADR_MSB:WH_ADR_LSB] == {cur_start_adr, 3'b000})
               && (hdr[WH_CHAN_MSB:WH_CHAN_LSB] == cur_channel_tag);

endmodule

// File: rtl/cbuf_fill_parser.sv
// Parses the CBUF tagged word stream read back from DDR3: headers, data bursts, XOR checksum.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | discard words until a marked fill header arrives
// ST_WFM_HDR | expect the marked waveform header
// ST_DATA    | forward num_bursts data words through the output register
// ST_CHECK   | expect the checksum word and compare against running XOR
module cbuf_fill_parser
  import cbuf_fmt_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  cbuf_fill_parser_if.slave bus,
  output logic [23:0] fill_num,
  output logic [1:0]  fill_type,
  output logic [13:0] num_bursts,
  output logic [15:0] pre_trig,
  output logic [22:0] start_adr,
  output logic [11:0] channel_tag,
  output logic [3:0]  xadc_alarms,
  output logic        hdr_valid,
  output logic        fill_done,
  output logic        chk_ok,
  output logic        err_tag,
  output logic        err_hdr,
  output logic        err_trunc,
  output logic        err_chk,
  input  logic        err_clr
);

  state_e         state;
  logic [127:0]   csum;
  logic [127:0]   dat_q;
  logic           dv_q;
  logic           last_q;
  logic [13:0]    cnt;

  logic [3:0]     tag;
  logic [127:0]   payload;
  logic           mark_ok;
  logic           accept;
  logic           last_burst;

  logic [23:0]    d_fill_num;
  logic [1:0]     d_fill_type;
  logic [13:0]    d_num_bursts;
  logic [15:0]    d_pre_trig;
  logic [22:0]    d_start_adr;
  logic [11:0]    d_channel_tag;
  logic [3:0]     d_alarms;
  logic           d_fill_sane;
  logic           d_wfm_ok;

  assign tag        = bus.in_dat[131:128];
  assign payload    = bus.in_dat[127:0];
  assign mark_ok    = (payload[MARK_MSB:MARK_LSB] == HDR_MARK);
  assign bus.in_ready = (state != ST_DATA) || !dv_q || bus.dat_ready;
  assign accept     = bus.in_valid && bus.in_ready;
  assign last_burst = (cnt == num_bursts - 14'd1);

  assign bus.dat_out   = dat_q;
  assign bus.dat_valid = dv_q;
  assign bus.dat_last  = last_q;

  cbuf_hdr_decode u_hdr_decode (
    .hdr             (payload[121:0]),
    .cur_num_bursts  (num_bursts),
    .cur_start_adr   (start_adr),
    .cur_channel_tag (channel_tag),
    .fill_num        (d_fill_num),
    .fill_type       (d_fill_type),
    .num_bursts      (d_num_bursts),
    .pre_trig        (d_pre_trig),
    .start_adr       (d_start_adr),
    .channel_tag     (d_channel_tag),
    .alarms          (d_alarms),
    .fill_sane       (d_fill_sane),
    .wfm_ok          (d_wfm_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      csum        <= '0;
      dat_q       <= '0;
      dv_q        <= 1'b0;
      last_q      <= 1'b0;
      cnt         <= '0;
      fill_num    <= '0;
      fill_type   <= '0;
      num_bursts  <= '0;
      pre_trig    <= '0;
      start_adr   <= '0;
      channel_tag <= '0;
      xadc_alarms <= '0;
      hdr_valid   <= 1'b0;
      fill_done   <= 1'b0;
      chk_ok      <= 1'b0;
      err_tag     <= 1'b0;
      err_hdr     <= 1'b0;
      err_trunc   <= 1'b0;
      err_chk     <= 1'b0;
    end else begin
      hdr_valid <= 1'b0;
      fill_done <= 1'b0;
      if (dv_q && bus.dat_ready) dv_q <= 1'b0;
      // clear first so that an error raised below in the same cycle wins
      if (err_clr) begin
        err_tag   <= 1'b0;
        err_hdr   <= 1'b0;
        err_trunc <= 1'b0;
        err_chk   <= 1'b0;
      end
      if (accept) begin
        if (tag == TAG_FILL && mark_ok) begin
          if (state != ST_IDLE) err_trunc <= 1'b1;
          if (!d_fill_sane) err_hdr <= 1'b1;
          fill_num    <= d_fill_num;
          fill_type   <= d_fill_type;
          num_bursts  <= d_num_bursts;
          pre_trig    <= d_pre_trig;
          start_adr   <= d_start_adr;
          channel_tag <= d_channel_tag;
          csum        <= payload;
          cnt         <= '0;
          chk_ok      <= 1'b0;
          state       <= ST_WFM_HDR;
        end else begin
          case (state)
            ST_WFM_HDR: begin
              if (tag == TAG_WFM && mark_ok) begin
                csum        <= csum ^ payload;
                xadc_alarms <= d_alarms;
                if (!d_wfm_ok) err_hdr <= 1'b1;
                hdr_valid   <= 1'b1;
                state       <= (num_bursts == 14'd0) ? ST_CHECK : ST_DATA;
              end else begin
                err_tag <= 1'b1;
                state   <= ST_IDLE;
              end
            end
            ST_DATA: begin
              if (tag == TAG_DAT) begin
                csum   <= csum ^ payload;
                dat_q  <= payload;
                dv_q   <= 1'b1;
                last_q <= last_burst;
                cnt    <= cnt + 14'd1;
                if (last_burst) state <= ST_CHECK;
              end else begin
                err_tag <= 1'b1;
                state   <= ST_IDLE;
              end
            end
            ST_CHECK: begin
              if (tag == TAG_CHK) begin
                chk_ok    <= (payload == csum);
                if (payload != csum) err_chk <= 1'b1;
                fill_done <= 1'b1;
              end else begin
                err_tag <= 1'b1;
              end
              state <= ST_IDLE;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_cbuf_fill_parser.sv
// Directed and randomized checks of cbuf_fill_parser against a word-level reference model.
module tb_cbuf_fill_parser;

  localparam logic [3:0] T_FILL = 4'd1;
  localparam logic [3:0] T_WFM  = 4'd2;
  localparam logic [3:0] T_DAT  = 4'd3;
  localparam logic [3:0] T_CHK  = 4'd4;

  typedef struct {
    logic [23:0] fn;
    logic [1:0]  ft;
    logic [13:0] nb;
    logic [15:0] pt;
    logic [22:0] sa;
    logic [11:0] ch;
    logic [3:0]  al;
  } fill_t;

  logic clk, rst_n, err_clr;
  logic [23:0] fill_num;
  logic [1:0]  fill_type;
  logic [13:0] num_bursts;
  logic [15:0] pre_trig;
  logic [22:0] start_adr;
  logic [11:0] channel_tag;
  logic [3:0]  xadc_alarms;
  logic hdr_valid, fill_done, chk_ok, err_tag, err_hdr, err_trunc, err_chk;

  logic man_ready, rand_ready, rr;
  int tests, fails;
  int hdr_cnt, done_cnt, hdr_base, done_base, rd;
  logic last_chk;
  logic [128:0] got_q[$];
  logic [128:0] exp_q[$];

  cbuf_fill_parser_if bus();
  assign bus.dat_ready = rand_ready ? rr : man_ready;

  cbuf_fill_parser dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .fill_num    (fill_num),
    .fill_type   (fill_type),
    .num_bursts  (num_bursts),
    .pre_trig    (pre_trig),
    .start_adr   (start_adr),
    .channel_tag (channel_tag),
    .xadc_alarms (xadc_alarms),
    .hdr_valid   (hdr_valid),
    .fill_done   (fill_done),
    .chk_ok      (chk_ok),
    .err_tag     (err_tag),
    .err_hdr     (err_hdr),
    .err_trunc   (err_trunc),
    .err_chk     (err_chk),
    .err_clr     (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rr = 1'b1;
    forever begin
      @(posedge clk);
      #1 rr = ($urandom_range(0, 1) == 1);
    end
  end

  // observe outputs mid-cycle; a handshake seen here completes at the next rising edge
  initial begin
    hdr_cnt = 0; done_cnt = 0; last_chk = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.dat_valid && bus.dat_ready) got_q.push_back({bus.dat_last, bus.dat_out});
        if (hdr_valid) hdr_cnt++;
        if (fill_done) begin
          done_cnt++;
          last_chk = chk_ok;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [131:0] obs, input logic [131:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [131:0] w);
    int n;
    bit ok;
    n = 0; ok = 1'b0;
    bus.in_dat = w;
    bus.in_valid = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_valid = 1'b0;
    check("send_accept", {131'd0, ok}, 132'd1);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic fill_t rand_fill(input logic [13:0] nb);
    fill_t f;
    logic [127:0] t;
    t = rnd128();
    f.fn = t[23:0];
    f.ft = t[25:24];
    f.pt = t[41:26];
    f.sa = t[64:42];
    f.ch = t[76:65];
    f.al = t[80:77];
    f.nb = nb;
    return f;
  endfunction

  function automatic logic [131:0] fill_word(input fill_t f);
    logic [127:0] p;
    p = rnd128();
    p[127:126] = 2'b01;
    p[23:0]    = f.fn;
    p[25:24]   = f.ft;
    p[40:27]   = f.nb;
    p[52:41]   = f.pt[11:0];
    p[75:53]   = f.sa;
    p[98:76]   = 23'd1;
    p[102:99]  = f.pt[15:12];
    p[103]     = 1'b1;
    p[121:110] = f.ch;
    return {T_FILL, p};
  endfunction

  function automatic logic [131:0] wfm_word(input fill_t f, input bit bad);
    logic [127:0] p;
    p = rnd128();
    p[127:126] = 2'b01;
    p[13:0]    = f.nb;
    p[51:26]   = {f.sa, 3'b000};
    p[109:98]  = f.ch;
    p[113:110] = f.al;
    if (bad) p[98] = ~p[98];
    return {T_WFM, p};
  endfunction

  // whole fill; checksum is the XOR of every payload sent for this fill
  task automatic do_fill(input fill_t f, input bit corrupt, input bit bad_wfm);
    logic [131:0] w;
    logic [127:0] x;
    int n;
    n = int'(f.nb);
    w = fill_word(f);          x = w[127:0];      send(w);
    w = wfm_word(f, bad_wfm);  x = x ^ w[127:0];  send(w);
    for (int i = 0; i < n; i++) begin
      w = {T_DAT, rnd128()};
      x = x ^ w[127:0];
      exp_q.push_back({(i == n - 1) ? 1'b1 : 1'b0, w[127:0]});
      send(w);
    end
    send({T_CHK, x ^ {127'd0, corrupt}});
  endtask

  task automatic mark_obs();
    hdr_base  = hdr_cnt;
    done_base = done_cnt;
    rd        = got_q.size();
    exp_q.delete();
  endtask

  task automatic check_obs(input string tag, input int e_hdr, input int e_done, input bit e_chk);
    int ng;
    ng = got_q.size() - rd;
    check({tag, "_nbursts"}, 132'(ng), 132'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < ng; i++)
      check({tag, "_burst"}, {3'd0, got_q[rd + i]}, {3'd0, exp_q[i]});
    check({tag, "_hdr_valid"}, 132'(hdr_cnt - hdr_base), 132'(e_hdr));
    check({tag, "_fill_done"}, 132'(done_cnt - done_base), 132'(e_done));
    if (e_done > 0) check({tag, "_chk_ok"}, {131'd0, last_chk}, {131'd0, e_chk});
  endtask

  task automatic check_errs(input string tag, input logic [3:0] e);
    check({tag, "_errs"}, {128'd0, err_tag, err_hdr, err_trunc, err_chk}, {128'd0, e});
  endtask

  task automatic check_fields(input string tag, input fill_t f);
    check({tag, "_fields"},
          {11'd0, fill_num, fill_type, num_bursts, pre_trig, start_adr, channel_tag, xadc_alarms},
          {11'd0, f.fn, f.ft, f.nb, f.pt, f.sa, f.ch, f.al});
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    settle(1);
    err_clr = 1'b0;
  endtask

  initial begin
    fill_t f, f2;
    logic [131:0] w[4];
    logic [127:0] x;
    bit corrupt, bad;
    tests = 0; fails = 0; rd = 0; hdr_base = 0; done_base = 0;
    rst_n = 1'b0; err_clr = 1'b0; man_ready = 1'b1; rand_ready = 1'b0;
    bus.in_valid = 1'b0; bus.in_dat = '0;
    settle(3);

    check("rst_fields", {5'd0, fill_num, fill_type, num_bursts, pre_trig, start_adr, channel_tag, xadc_alarms}, 132'd0);
    check("rst_dat_out", {4'd0, bus.dat_out}, 132'd0);
    check("rst_flags", {125'd0, bus.dat_valid, bus.dat_last, hdr_valid, fill_done, chk_ok, 2'b00}, 132'd0);
    check_errs("rst", 4'b0000);
    check("rst_in_ready", {131'd0, bus.in_ready}, 132'd1);
    rst_n = 1'b1;
    settle(1);

    // nominal fill
    mark_obs();
    f = rand_fill(14'd3);
    f.fn = 24'h00002A;
    do_fill(f, 1'b0, 1'b0);
    settle(3);
    check_obs("nominal", 1, 1, 1'b1);
    check_fields("nominal", f);
    check_errs("nominal", 4'b0000);

    // checksum corrupted in bit 0
    mark_obs();
    f = rand_fill(14'd2);
    do_fill(f, 1'b1, 1'b0);
    settle(3);
    check_obs("badchk", 1, 1, 1'b0);
    check_errs("badchk", 4'b0001);
    settle(5);
    check_errs("badchk_sticky", 4'b0001);
    clear_errs();
    check_errs("badchk_clr", 4'b0000);

    // zero bursts
    mark_obs();
    f = rand_fill(14'd0);
    do_fill(f, 1'b0, 1'b0);
    settle(3);
    check_obs("nb0", 1, 1, 1'b1);
    check_errs("nb0", 4'b0000);

    // waveform header disagreeing with the fill header
    mark_obs();
    f = rand_fill(14'd1);
    do_fill(f, 1'b0, 1'b1);
    settle(3);
    check_obs("badwfm", 1, 1, 1'b1);
    check_errs("badwfm", 4'b0100);
    clear_errs();

    // truncated fill: new fill header after 1 of 4 bursts
    mark_obs();
    f = rand_fill(14'd4);
    send(fill_word(f));
    send(wfm_word(f, 1'b0));
    w[0] = {T_DAT, rnd128()};
    exp_q.push_back({1'b0, w[0][127:0]});
    send(w[0]);
    f2 = rand_fill(14'd2);
    do_fill(f2, 1'b0, 1'b0);
    settle(3);
    check_obs("trunc", 2, 1, 1'b1);
    check_fields("trunc", f2);
    check_errs("trunc", 4'b0010);
    clear_errs();

    // back-pressure: downstream stalls for 5 cycles after the first burst
    mark_obs();
    f = rand_fill(14'd4);
    for (int i = 0; i < 4; i++) begin
      w[i] = {T_DAT, rnd128()};
      exp_q.push_back({(i == 3) ? 1'b1 : 1'b0, w[i][127:0]});
    end
    send(fill_word(f));
    x = bus.in_dat[127:0];
    send(wfm_word(f, 1'b0));
    x = x ^ bus.in_dat[127:0];
    man_ready = 1'b0;
    send(w[0]);
    bus.in_dat = w[1];
    bus.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_in_ready", {131'd0, bus.in_ready}, 132'd0);
      check("stall_dat", {3'd0, bus.dat_valid, bus.dat_last, bus.dat_out}, {3'd0, 1'b1, 1'b0, w[0][127:0]});
    end
    @(posedge clk);
    #1 man_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      x = x ^ w[i][127:0];
      if (i > 0) send(w[i]);
    end
    send({T_CHK, x});
    settle(3);
    check_obs("stall", 1, 1, 1'b1);
    check_errs("stall", 4'b0000);

    // data word in IDLE is dropped silently; data word in place of waveform header is a tag error
    mark_obs();
    send({T_DAT, rnd128()});
    settle(2);
    check_errs("idle_dat", 4'b0000);
    f = rand_fill(14'd2);
    send(fill_word(f));
    send({T_DAT, rnd128()});
    settle(2);
    check_obs("tagerr", 0, 0, 1'b0);
    check_errs("tagerr", 4'b1000);
    clear_errs();
    mark_obs();
    f = rand_fill(14'd2);
    do_fill(f, 1'b0, 1'b0);
    settle(3);
    check_obs("after_tagerr", 1, 1, 1'b1);
    check_errs("after_tagerr", 4'b0000);

    // randomized fills with random downstream readiness
    for (int k = 0; k < 8; k++) begin
      corrupt = ($urandom_range(0, 3) == 0);
      bad     = ($urandom_range(0, 3) == 0);
      mark_obs();
      f = rand_fill(14'($urandom_range(0, 6)));
      rand_ready = 1'b1;
      do_fill(f, corrupt, bad);
      rand_ready = 1'b0;
      settle(4);
      check_obs("rand", 1, 1, !corrupt);
      check_fields("rand", f);
      check_errs("rand", {1'b0, bad, 1'b0, corrupt});
      clear_errs();
    end

    // reset in the middle of a stalled fill drops the pending burst
    man_ready = 1'b0;
    f = rand_fill(14'd2);
    send(fill_word(f));
    send(wfm_word(f, 1'b0));
    send({T_DAT, rnd128()});
    check("midrst_pending", {131'd0, bus.dat_valid}, 132'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_dat_valid", {131'd0, bus.dat_valid}, 132'd0);
    check("midrst_fields", {108'd0, fill_num}, 132'd0);
    settle(2);
    rst_n = 1'b1;
    man_ready = 1'b1;
    settle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
